// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between a scan-driver consumer and the display driver:
// scan/seconds toggles and digit value in, multiplexed display drive and pulses out.
interface seg7_scan_driver_if;
    logic        digit_clk;
    logic        divided_clk;
    logic [15:0] digits;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        sec_tick;
    logic        frame_done;

    modport master (
        output digit_clk, divided_clk, digits,
        input  an, seg, dp, sec_tick, frame_done
    );

    modport slave (
        input  digit_clk, divided_clk, digits,
        output an, seg, dp, sec_tick, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit HH:MM driver for a 7-segment display with
// anti-ghosting blanking, frame-synchronous digit snapshot, colon flash and seconds tick.
module seg7_scan_driver #(
    parameter int unsigned GHOST_CYCLES       = 2,
    parameter bit          BLANK_LEADING_ZERO = 1'b1,
    parameter bit          AN_ACTIVE_LOW      = 1'b1,
    parameter bit          SEG_ACTIVE_LOW     = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [7:0] GHOST_LD = 8'(GHOST_CYCLES);
    localparam logic [3:0] AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF   = SEG_ACTIVE_LOW;

    // Active-high gfedcba pattern; a zero in the leftmost position may be blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic lead_pos);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        if (lead_pos && BLANK_LEADING_ZERO && (nib == 4'd0)) begin
            pat = 7'h00;
        end else begin
            pat = pat;
        end
        return pat;
    endfunction

    logic        r_armed;
    logic        r_dclk_prev;
    logic        r_sclk_prev;
    logic [1:0]  r_idx;
    state_t      r_state;
    logic [7:0]  r_blank_cnt;
    logic [15:0] r_snapshot;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_sec_tick;
    logic        r_frame_done;

    logic        w_step;
    logic        w_rise;
    logic        w_wrap;
    logic [1:0]  w_idx_nxt;
    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] w_snap_nxt;
    logic [3:0]  w_nib;
    logic [6:0]  w_pat;
    logic [3:0]  w_an_nxt;
    logic [6:0]  w_seg_nxt;
    logic        w_dp_nxt;

    // Edge detection and next scan position / blanking state.
    always_comb begin
        w_step      = 1'b0;
        w_rise      = 1'b0;
        w_wrap      = 1'b0;
        w_idx_nxt   = r_idx;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_blank_cnt;
        w_snap_nxt  = r_snapshot;
        if (r_armed) begin
            w_step = bus.digit_clk ^ r_dclk_prev;
            w_rise = bus.divided_clk & ~r_sclk_prev;
        end else begin
            w_step = 1'b0;
            w_rise = 1'b0;
        end
        if (w_step) begin
            w_idx_nxt   = r_idx + 2'd1;
            w_cnt_nxt   = GHOST_LD;
            w_state_nxt = (GHOST_LD == 8'd0) ? ST_SHOW : ST_BLANK;
            // Latch the whole frame at the wrap so a mid-frame update cannot tear.
            if (w_idx_nxt == 2'd0) begin
                w_snap_nxt = bus.digits;
                w_wrap     = 1'b1;
            end else begin
                w_snap_nxt = r_snapshot;
                w_wrap     = 1'b0;
            end
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_blank_cnt <= 8'd1) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_cnt_nxt   = r_blank_cnt - 8'd1;
                        w_state_nxt = ST_BLANK;
                    end
                end
                ST_SHOW: w_state_nxt = ST_SHOW;
                ST_OFF:  w_state_nxt = ST_OFF;
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    // Display drive derived from the next state so an/seg/dp move together.
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = DP_OFF;
        w_nib     = 4'd0;
        w_pat     = 7'h00;
        case (w_idx_nxt)
            2'd0:    w_nib = w_snap_nxt[3:0];
            2'd1:    w_nib = w_snap_nxt[7:4];
            2'd2:    w_nib = w_snap_nxt[11:8];
            2'd3:    w_nib = w_snap_nxt[15:12];
            default: w_nib = 4'd0;
        endcase
        w_pat = seg_decode(w_nib, (w_idx_nxt == 2'd3));
        if (w_state_nxt == ST_SHOW) begin
            w_an_nxt  = AN_OFF ^ (4'b0001 << w_idx_nxt);
            w_seg_nxt = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
            w_dp_nxt  = ((w_idx_nxt == 2'd2) && bus.divided_clk) ? ~DP_OFF : DP_OFF;
        end else begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_OFF;
            w_dp_nxt  = DP_OFF;
        end
    end

    // Scan FSM, input history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed      <= 1'b0;
            r_dclk_prev  <= 1'b0;
            r_sclk_prev  <= 1'b0;
            r_idx        <= 2'd3;
            r_state      <= ST_OFF;
            r_blank_cnt  <= 8'd0;
            r_snapshot   <= 16'h0000;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_sec_tick   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_dclk_prev  <= bus.digit_clk;
            r_sclk_prev  <= bus.divided_clk;
            r_idx        <= w_idx_nxt;
            r_state      <= w_state_nxt;
            r_blank_cnt  <= w_cnt_nxt;
            r_snapshot   <= w_snap_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_sec_tick   <= w_rise;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.sec_tick   = r_sec_tick;
    assign bus.frame_done = r_frame_done;

endmodule
